hazard_scoreboard: RTL and testbench

Parametrised ID-stage hazard unit for the in-order RV32 pipeline. It keeps a shift-register scoreboard of in-flight destination registers, one entry per stage after ID. Each cycle it compares the ID instruction's decoded sources against the scoreboard and produces the pipeline stall/bubble. An optional forwarding mode replaces stalls with bypass selects, stalling only on load-use.

---
 rtl/hazard_scoreboard.sv | 161 ++++++++++++++++
 tb/tb_hazard_scoreboard.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: ID-stage RAW hazard unit for the in-order RV32 pipeline.
//
// A shift-register scoreboard holds one {valid, rd, is_load} entry per stage
// after ID (entry 0 = EX ... entry STAGES-1 = WB). Each cycle the decoded
// sources of the ID instruction are compared against the scoreboard to
// produce a stall (FWD_EN=0) or bypass selects with load-use stall (FWD_EN=1).
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   id_ins        instruction currently in ID
//   id_valid      ID holds a real instruction
//   ext_stall     stall request from elsewhere (memory, etc.)
//   csr_stall     stall request from CSR/trap logic
//   flush         squash all in-flight entries at the next edge
//   stall_o       hold PC/IF/ID and insert a bubble into EX
//   hazard_rs1_o  rs1 RAW hazard causing a stall
//   hazard_rs2_o  rs2 RAW hazard causing a stall
//   fwd_sel_rs1   0 = regfile, k = forward from entry k-1 (FWD_EN=1 only)
//   fwd_sel_rs2   same for rs2
//   stall_cnt     saturating count of cycles with stall_o=1
//
// There is no FSM and no valid/ready handshake: all outputs are a pure
// function of the scoreboard and the current ID inputs.

module hazard_scoreboard #(
    parameter int STAGES = 3,
    parameter bit FWD_EN = 1'b0,
    parameter int CNT_W  = 16,
    parameter int SELW   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      id_ins,
    input  logic             id_valid,
    input  logic             ext_stall,
    input  logic             csr_stall,
    input  logic             flush,
    output logic             stall_o,
    output logic             hazard_rs1_o,
    output logic             hazard_rs2_o,
    output logic [SELW-1:0]  fwd_sel_rs1,
    output logic [SELW-1:0]  fwd_sel_rs2,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // Scoreboard entries
    logic [STAGES-1:0] ent_valid;
    logic [4:0]        ent_rd [STAGES];
    logic [STAGES-1:0] ent_load;

    // Decode
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [4:0] rd, rs1, rs2;
    logic       writes_rd, uses_rs1, uses_rs2, is_load;

    assign opcode = id_ins[6:0];
    assign funct3 = id_ins[14:12];
    assign rd     = id_ins[11:7];
    assign rs1    = id_ins[19:15];
    assign rs2    = id_ins[24:20];

    always_comb begin
        writes_rd = 1'b0;
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        is_load   = (opcode == OP_LOAD);
        unique case (opcode)
            OP_R:      begin writes_rd = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            OP_I:      begin writes_rd = 1'b1; uses_rs1 = 1'b1; end
            OP_LOAD:   begin writes_rd = 1'b1; uses_rs1 = 1'b1; end
            OP_STORE:  begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            OP_BRANCH: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            OP_LUI:    writes_rd = 1'b1;
            OP_AUIPC:  writes_rd = 1'b1;
            OP_JAL:    writes_rd = 1'b1;
            OP_JALR:   begin writes_rd = 1'b1; uses_rs1 = 1'b1; end
            OP_SYSTEM: begin
                writes_rd = (funct3 != 3'd0);
                // CSRR{W,S,C} read rs1; the immediate forms (funct3[2]=1) do not.
                uses_rs1  = (funct3 != 3'd0) && !funct3[2];
            end
            default: ;
        endcase
    end

    // Match vectors
    logic [STAGES-1:0] m1, m2;
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            m1[k] = id_valid && uses_rs1 && (rs1 != 5'd0) && ent_valid[k] && (ent_rd[k] == rs1);
            m2[k] = id_valid && uses_rs2 && (rs2 != 5'd0) && ent_valid[k] && (ent_rd[k] == rs2);
        end
    end

    // Hazard / forward selection
    always_comb begin
        hazard_rs1_o = 1'b0;
        hazard_rs2_o = 1'b0;
        fwd_sel_rs1  = '0;
        fwd_sel_rs2  = '0;
        if (!FWD_EN) begin
            hazard_rs1_o = |m1;
            hazard_rs2_o = |m2;
        end else begin
            hazard_rs1_o = m1[0] && ent_load[0];
            hazard_rs2_o = m2[0] && ent_load[0];
            // Walk oldest to youngest so the youngest match is the final write.
            for (int k = STAGES - 1; k >= 0; k--) begin
                if (m1[k]) fwd_sel_rs1 = SELW'(k + 1);
                if (m2[k]) fwd_sel_rs2 = SELW'(k + 1);
            end
            // While stalling on load-use the bypass is meaningless; keep it at regfile.
            if (hazard_rs1_o) fwd_sel_rs1 = '0;
            if (hazard_rs2_o) fwd_sel_rs2 = '0;
        end
    end

    assign stall_o = hazard_rs1_o | hazard_rs2_o | ext_stall | csr_stall;

    // Entry 0 takes the ID instruction only if it actually leaves ID this cycle.
    logic load_en;
    assign load_en = id_valid && !stall_o && !flush && writes_rd && (rd != 5'd0);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            ent_valid <= '0;
            ent_load  <= '0;
            for (int k = 0; k < STAGES; k++) ent_rd[k] <= 5'd0;
        end else begin
            for (int k = 1; k < STAGES; k++) begin
                ent_valid[k] <= ent_valid[k-1];
                ent_rd[k]    <= ent_rd[k-1];
                ent_load[k]  <= ent_load[k-1];
            end
            ent_valid[0] <= load_en;
            ent_rd[0]    <= load_en ? rd : 5'd0;
            ent_load[0]  <= load_en && is_load;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall_o && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard. Three instances share the stimulus:
// d0 (STAGES=3, FWD_EN=0), d1 (FWD_EN=1), d2 (CNT_W=2, FWD_EN=0).

module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst, id_valid, ext_stall, csr_stall, flush;
    logic [31:0] id_ins;

    logic        s0, h10, h20, s1, h11, h21, s2, h12, h22;
    logic [2:0]  f10, f20, f11, f21, f12, f22;
    logic [15:0] c0, c1;
    logic [1:0]  c2;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] ADDI_X1   = 32'h0010_0093; // addi x1,x0,1
    localparam logic [31:0] ADD_X2    = 32'h0010_8133; // add x2,x1,x1
    localparam logic [31:0] LW_X5     = 32'h0000_A283; // lw x5,0(x1)
    localparam logic [31:0] ADD_X6    = 32'h0002_8333; // add x6,x5,x0
    localparam logic [31:0] ADDI_X7   = 32'h0070_0393; // addi x7,x0,7
    localparam logic [31:0] SW_X7     = 32'h0071_2023; // sw x7,0(x2)
    localparam logic [31:0] ADDI_X0   = 32'h0050_0013; // addi x0,x0,5
    localparam logic [31:0] ADD_X3_00 = 32'h0000_01B3; // add x3,x0,x0

    always #5 clk = ~clk;

    hazard_scoreboard #(.STAGES(3), .FWD_EN(1'b0), .CNT_W(16), .SELW(3)) d0 (
        .clk(clk), .rst(rst), .id_ins(id_ins), .id_valid(id_valid),
        .ext_stall(ext_stall), .csr_stall(csr_stall), .flush(flush),
        .stall_o(s0), .hazard_rs1_o(h10), .hazard_rs2_o(h20),
        .fwd_sel_rs1(f10), .fwd_sel_rs2(f20), .stall_cnt(c0));

    hazard_scoreboard #(.STAGES(3), .FWD_EN(1'b1), .CNT_W(16), .SELW(3)) d1 (
        .clk(clk), .rst(rst), .id_ins(id_ins), .id_valid(id_valid),
        .ext_stall(ext_stall), .csr_stall(csr_stall), .flush(flush),
        .stall_o(s1), .hazard_rs1_o(h11), .hazard_rs2_o(h21),
        .fwd_sel_rs1(f11), .fwd_sel_rs2(f21), .stall_cnt(c1));

    hazard_scoreboard #(.STAGES(3), .FWD_EN(1'b0), .CNT_W(2), .SELW(3)) d2 (
        .clk(clk), .rst(rst), .id_ins(id_ins), .id_valid(id_valid),
        .ext_stall(ext_stall), .csr_stall(csr_stall), .flush(flush),
        .stall_o(s2), .hazard_rs1_o(h12), .hazard_rs2_o(h22),
        .fwd_sel_rs1(f12), .fwd_sel_rs2(f22), .stall_cnt(c2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // on the falling edge.
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; id_ins = 32'h0; id_valid = 1'b0;
        ext_stall = 1'b0; csr_stall = 1'b0; flush = 1'b0;
        nxt();
        rst = 1'b0;
    endtask

    initial begin
        #1;
        do_reset();

        // Reset state
        smp();
        chk("rst_stall0", {31'd0, s0}, 32'd0);
        chk("rst_haz0", {30'd0, h10, h20}, 32'd0);
        chk("rst_fwd1", {26'd0, f11, f21}, 32'd0);
        chk("rst_cnt0", {16'd0, c0}, 32'd0);
        csr_stall = 1'b1;
        #1;
        chk("rst_csr_stall", {31'd0, s0}, 32'd1);
        csr_stall = 1'b0;
        nxt();

        // Scenario 1: addi x1 ; add x2,x1,x1 without forwarding -> 3 stalls
        do_reset();
        id_valid = 1'b1; id_ins = ADDI_X1;
        smp(); chk("s1_addi_nostall", {31'd0, s0}, 32'd0);
        nxt();
        id_ins = ADD_X2;
        for (int i = 0; i < 3; i++) begin
            smp();
            chk($sformatf("s1_stall_c%0d", i), {31'd0, s0}, 32'd1);
            chk($sformatf("s1_haz_c%0d", i), {30'd0, h10, h20}, 32'd3);
            chk($sformatf("s1_fwd_c%0d", i), {26'd0, f10, f20}, 32'd0);
            nxt();
        end
        smp();
        chk("s1_proceed", {31'd0, s0}, 32'd0);
        chk("s1_cnt", {16'd0, c0}, 32'd3);
        nxt();

        // Scenario 2: lw x5 ; add x6,x5,x0 with forwarding -> 1 stall then MEM bypass
        do_reset();
        id_valid = 1'b1; id_ins = LW_X5;
        smp(); chk("s2_lw_nostall", {31'd0, s1}, 32'd0);
        nxt();
        id_ins = ADD_X6;
        smp();
        chk("s2_loaduse_stall", {31'd0, s1}, 32'd1);
        chk("s2_loaduse_haz1", {31'd0, h11}, 32'd1);
        chk("s2_loaduse_haz2", {31'd0, h21}, 32'd0);
        nxt();
        smp();
        chk("s2_after_stall", {31'd0, s1}, 32'd0);
        chk("s2_fwd1", {29'd0, f11}, 32'd2);
        chk("s2_fwd2", {29'd0, f21}, 32'd0);
        chk("s2_cnt", {16'd0, c1}, 32'd1);
        nxt();

        // Scenario 3: addi x7 ; sw x7 -> EX bypass; x0 never matches
        do_reset();
        id_valid = 1'b1; id_ins = ADDI_X7;
        nxt();
        id_ins = SW_X7;
        smp();
        chk("s3_sw_nostall", {31'd0, s1}, 32'd0);
        chk("s3_sw_fwd2", {29'd0, f21}, 32'd1);
        chk("s3_sw_fwd1", {29'd0, f11}, 32'd0);
        nxt();
        id_ins = ADDI_X0;
        nxt();
        id_ins = ADD_X3_00;
        smp();
        chk("s3_x0_stall_d0", {31'd0, s0}, 32'd0);
        chk("s3_x0_stall_d1", {31'd0, s1}, 32'd0);
        chk("s3_x0_fwd_d1", {26'd0, f11, f21}, 32'd0);
        nxt();

        // Scenario 4: flush squashes addi x1 sitting in EX
        do_reset();
        id_valid = 1'b1; id_ins = ADDI_X1;
        nxt();
        id_ins = ADD_X2; flush = 1'b1;
        smp();
        chk("s4_flush_cycle_stall", {31'd0, s0}, 32'd1);
        nxt();
        flush = 1'b0;
        smp();
        chk("s4_after_flush", {31'd0, s0}, 32'd0);
        chk("s4_after_flush_haz", {30'd0, h10, h20}, 32'd0);
        nxt();

        // Scenario 5: 2-bit counter saturates; held addi x1 leaves only bubbles
        do_reset();
        id_valid = 1'b1; id_ins = ADDI_X1; ext_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            nxt();
            smp();
            chk($sformatf("s5_cnt_%0d", i), {30'd0, c2}, (i < 3) ? 32'(i + 1) : 32'd3);
        end
        nxt();
        ext_stall = 1'b0; id_ins = ADD_X2;
        smp();
        chk("s5_bubbles_only", {31'd0, s2}, 32'd0);
        nxt();

        // Scenario 6: reset on the second stall cycle of scenario 1
        do_reset();
        id_valid = 1'b1; id_ins = ADDI_X1;
        nxt();
        id_ins = ADD_X2;
        smp(); chk("s6_stall_c0", {31'd0, s0}, 32'd1);
        nxt();
        rst = 1'b1;
        smp(); chk("s6_stall_c1", {31'd0, s0}, 32'd1);
        nxt();
        rst = 1'b0;
        smp();
        chk("s6_after_rst_stall", {31'd0, s0}, 32'd0);
        chk("s6_after_rst_cnt", {16'd0, c0}, 32'd0);
        nxt();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
